// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for a 5-stage in-order pipeline.
// This block resolves three hazards, in priority order:
//   - a data-memory stall, which freezes the whole pipeline
//   - a taken branch, which flushes IF/ID, ID/EX and EX/MEM
//   - a load-use hazard, which inserts a one-cycle bubble
// Every output is combinational from the registered state and the current inputs.
// Optional build macro PIPE_PERF_CNT_EN adds two saturating 16-bit event counters,
// stall_cnt and flush_cnt.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal issue; branch and load-use are evaluated
// FLUSH   | a branch flush happened last cycle; IF/ID holds a bubble
// MEMWAIT | the pipeline was frozen last cycle; a held branch resolves
//         | on the first cycle that mem_stall_req is low

module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic        exmem_branch,
    input  logic        exmem_zero,
    input  logic        mem_stall_req,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        hazard_detected,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic        pc_src,
    output logic        pipe_freeze
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic branch_taken;
    logic load_use;

    // Event decode. Register 0 is hard-wired to zero, so a load into it never
    // creates a dependency.
    always_comb begin
        branch_taken = exmem_branch & exmem_zero;
        load_use     = idex_memread && (idex_rt != 5'd0) &&
                       ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    end

    // State register. Reset returns to RUN, which drops any branch held in MEMWAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. Priority: reset, memory stall, taken branch, load-use.
    always_comb begin
        state_next      = RUN;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        hazard_detected = 1'b0;
        flush_ifid      = 1'b0;
        flush_idex      = 1'b0;
        flush_exmem     = 1'b0;
        pc_src          = 1'b0;
        pipe_freeze     = 1'b0;

        if (reset) begin
            state_next = RUN;
        end else if (mem_stall_req) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            state_next  = MEMWAIT;
        end else begin
            case (state)
                RUN, MEMWAIT: begin
                    if (branch_taken) begin
                        pc_src      = 1'b1;
                        flush_ifid  = 1'b1;
                        flush_idex  = 1'b1;
                        flush_exmem = 1'b1;
                        state_next  = FLUSH;
                    end else if (load_use) begin
                        pc_write        = 1'b0;
                        ifid_write      = 1'b0;
                        hazard_detected = 1'b1;
                        state_next      = RUN;
                    end else begin
                        state_next = RUN;
                    end
                end
                // IF/ID holds the bubble from the flush, so its register fields
                // are meaningless and load-use is not evaluated here.
                FLUSH: begin
                    state_next = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating event counters. The outputs above are already zero during
    // reset, so the event terms need no separate reset qualification.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if ((pipe_freeze || hazard_detected) && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (pc_src && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports `clk`, in, 1, the single clock; every register updates on its rising edge.
REQ-002 SHALL have `reset`, in, 1, synchronous active-high reset, sampled on the `clk` rising edge.
REQ-003 SHALL have `ifid_rs` and `ifid_rt`, in, 5 each: source register fields of the instruction held in IF/ID.
REQ-004 SHALL have `idex_memread`, in, 1, and `idex_rt`, in, 5: load flag and destination of the instruction in ID/EX.
REQ-005 SHALL have `exmem_branch` and `exmem_zero`, in, 1 each; branch_taken = `exmem_branch` & `exmem_zero`.
REQ-006 SHALL have `mem_stall_req`, in, 1: data memory not ready; the whole pipeline must freeze while it is high.
REQ-007 SHALL have `pc_write`, out, 1, and `ifid_write`, out, 1: PC and IF/ID write enables.
REQ-008 SHALL have `hazard_detected`, out, 1, driven into the main control decoder to zero all ID-stage control bits.
REQ-009 SHALL have `flush_ifid`, `flush_idex` and `flush_exmem`, out, 1 each: synchronous clears of the pipeline registers.
REQ-010 SHALL have `pc_src`, out, 1: selects the branch target for the next PC.
REQ-011 SHALL have `pipe_freeze`, out, 1: holds ID/EX, EX/MEM and MEM/WB.
REQ-012 SHALL have `stall_cnt` and `flush_cnt`, out, 16 each, present only under PIPE_PERF_CNT_EN.

Function
REQ-013 SHALL implement a registered FSM with states RUN, FLUSH and MEMWAIT; all outputs are combinational from the state and the current inputs.
REQ-014 In any state, `mem_stall_req`=1 SHALL force `pipe_freeze`=1, `pc_write`=0 and `ifid_write`=0, with all flushes 0 and `pc_src`=0, and the next state SHALL be MEMWAIT.
REQ-015 Priority SHALL be `mem_stall_req` > branch_taken > load-use.
REQ-016 In RUN or MEMWAIT with `mem_stall_req`=0 and branch_taken=1, `pc_src`, `flush_ifid`, `flush_idex` and `flush_exmem` SHALL all be 1 for exactly that cycle, `pc_write`=1, and the next state SHALL be FLUSH.
REQ-017 In MEMWAIT, a branch_taken held during the freeze SHALL take effect on the first cycle with `mem_stall_req`=0, never earlier.
REQ-018 Load-use SHALL be detected when `idex_memread`=1, `idex_rt`!=0 and (`idex_rt`==`ifid_rs` or `idex_rt`==`ifid_rt`).
REQ-019 When load-use is detected and no higher-priority event is present, `pc_write`=0, `ifid_write`=0 and `hazard_detected`=1 SHALL hold for that cycle only, and the next state SHALL be RUN.
REQ-020 In FLUSH, load-use detection SHALL be suppressed because IF/ID holds a bubble; outputs SHALL be the defaults, and the next state SHALL be RUN, or MEMWAIT if `mem_stall_req`=1.
REQ-021 Defaults, when no event is present: `pc_write`=1, `ifid_write`=1, and every other output 0.
REQ-022 MEMWAIT with no request and no branch SHALL evaluate load-use as RUN does, then return to RUN.

Reset
REQ-023 `reset`=1 SHALL set the state to RUN and clear both counters to 0.
REQ-024 While `reset`=1, outputs SHALL be the defaults and all inputs SHALL be ignored.
REQ-025 Reset asserted in FLUSH or MEMWAIT SHALL abandon any deferred branch.

Configuration
REQ-026 Macro PIPE_PERF_CNT_EN SHALL gate the performance counters.
REQ-027 With PIPE_PERF_CNT_EN defined:
- `stall_cnt` increments on each load-use stall cycle and each `mem_stall_req` cycle.
- `flush_cnt` increments on each branch flush cycle.
- Both saturate at 16'hFFFF.
REQ-028 Without PIPE_PERF_CNT_EN, the counter ports and registers SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Load-use: `idex_memread`=1, `idex_rt`=5, `ifid_rs`=5 -> one cycle of `pc_write`=0, `ifid_write`=0, `hazard_detected`=1; the next cycle (`idex_memread`=0) returns to defaults.
REQ-030 Zero register: `idex_memread`=1, `idex_rt`=0, `ifid_rt`=0 -> no stall.
REQ-031 Branch: `exmem_branch`=1, `exmem_zero`=1 -> that cycle shows `pc_src`=1 and all three flushes=1; the next cycle shows defaults even with a load-use match.
REQ-032 Deferred branch: `mem_stall_req`=1 for 3 cycles with branch_taken=1 -> `pipe_freeze`=1 for 3 cycles, no flush; the 4th cycle shows `pc_src`=1 and all flushes=1.
REQ-033 Reset: `reset`=1 during MEMWAIT -> the next cycle is RUN with defaults; counters read 0.
REQ-034 Counters (with PIPE_PERF_CNT_EN): 2 load-use stalls, 1 flush and 3 mem-wait cycles -> `stall_cnt`=5, `flush_cnt`=1.
